// File: rtl/vga_vram_arbiter_if.sv
// Host write handshake, video RAM port and line-buffer write port of the VRAM arbiter.
// The arbiter uses the slave view; whoever owns the host, RAM and line buffer uses the master view.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              lb_we;
  logic [5:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;

  modport slave (
    input  host_valid, host_addr, host_data, ram_rdata,
    output host_ready, ram_addr, ram_we, ram_wdata, lb_we, lb_addr, lb_wdata
  );

  modport master (
    output host_valid, host_addr, host_data, ram_rdata,
    input  host_ready, ram_addr, ram_we, ram_wdata, lb_we, lb_addr, lb_wdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: prefetches the next display row into the line buffer during
// horizontal blanking and grants host writes at all other times.
module vga_vram_arbiter #(
  parameter int FETCH_WORDS = 40,
  parameter int SCALE_LOG2  = 2,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int H_VISIBLE   = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_VISIBLE   = 480,
  parameter int V_TOTAL     = 525
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  vga_vram_arbiter_if.slave    bus,
  output logic                 fetch_busy,
  output logic                 underrun
);

  localparam int                IDX_W      = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1;
  localparam logic [9:0]        H_TRIG     = 10'(H_VISIBLE);
  localparam logic [9:0]        H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]        V_LAST_VIS = 10'(V_VISIBLE - 1);
  localparam logic [9:0]        V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(FETCH_WORDS - 1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(FETCH_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx_p0;
  logic [ADDR_W-1:0] base_p0;
  logic              vld_p1;
  logic [5:0]        lb_addr_p1;
  logic              trig;

  // The last scanline of the frame prefetches row 0 for the next frame.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [9:0] v);
    logic [9:0] row;
    row = (v == V_LAST) ? 10'd0 : ((v + 10'd1) >> SCALE_LOG2);
    return ADDR_W'(row) * STRIDE;
  endfunction

  assign trig = (h_cnt == H_TRIG) &&
                (((v_cnt < V_LAST_VIS) && (v_cnt[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b1}})) ||
                 (v_cnt == V_LAST));

  assign fetch_busy     = (state != IDLE);
  assign bus.host_ready = (state == IDLE) && !rst && !trig;
  assign bus.ram_we     = bus.host_valid && bus.host_ready;
  assign bus.ram_addr   = (state == FETCH) ? (base_p0 + ADDR_W'(idx_p0)) : bus.host_addr;
  assign bus.ram_wdata  = bus.host_data;
  assign bus.lb_we      = vld_p1;
  assign bus.lb_addr    = lb_addr_p1;
  assign bus.lb_wdata   = bus.ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx_p0     <= '0;
      vld_p1     <= 1'b0;
      lb_addr_p1 <= '0;
      underrun   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            state   <= FETCH;
            idx_p0  <= '0;
            base_p0 <= row_base_of(v_cnt);
          end
        end
        // p0 -> p1: the word addressed this cycle returns from RAM next cycle
        FETCH: begin
          vld_p1     <= 1'b1;
          lb_addr_p1 <= 6'(idx_p0);
          idx_p0     <= idx_p0 + IDX_W'(1);
          if (idx_p0 == IDX_LAST) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
      // Line ended before the fetch finished: abandon it and flag the glitch.
      if ((h_cnt == H_LAST) && (state != IDLE)) begin
        underrun <= 1'b1;
        state    <= IDLE;
        vld_p1   <= 1'b0;
      end
    end
  end

endmodule
